// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    // Fetch FSM: idle, request in flight, or request in flight whose data is stale.
    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_DROP = 2'd2
    } ifu_state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO: DEPTH x W storage with push/pop/flush; flush wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: prefetches sequential words over req/ack into a FIFO,
// hands {instr, pc} to the core, and flushes/refetches on redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] fetch_pc_out
);
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    ifu_state_t    state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt, addr_q, addr_nxt;
    fetch_entry_t  push_data, head, hold_q;
    logic          push, pop, full, empty, outstanding, space_after;
    logic [CW-1:0] count;
    logic [CW:0]   occ_after;

    // A request is in flight whenever the FSM is not idle.
    assign outstanding = (state != IFU_IDLE);
    assign push        = (state == IFU_REQ) && mem_ack && !redirect_valid && !full;
    assign pop         = !empty && ir_ready && !redirect_valid;
    assign push_data   = {mem_rdata, addr_q};
    assign occ_after   = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign space_after = (occ_after < DEPTH_C);

    fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .flush (redirect_valid),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign ir_valid     = !empty;
    assign ir           = empty ? hold_q.instr : head.instr;
    assign ir_pc        = empty ? hold_q.pc    : head.pc;
    assign mem_req      = outstanding;
    assign mem_addr     = addr_q;
    assign fetch_pc_out = fetch_pc;

    // Next state, next fetch address and the address presented with the next request.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        addr_nxt     = addr_q;
        if (push)           fetch_pc_nxt = fetch_pc + WORD_BYTES;
        if (redirect_valid) fetch_pc_nxt = word_align(redirect_pc);
        case (state)
            IFU_IDLE: if (redirect_valid || space_after) state_nxt = IFU_REQ;
            IFU_REQ: begin
                if (mem_ack)             state_nxt = (redirect_valid || space_after) ? IFU_REQ : IFU_IDLE;
                else if (redirect_valid) state_nxt = IFU_DROP;
            end
            // The stale request must complete before the redirected one can start.
            IFU_DROP: if (mem_ack) state_nxt = IFU_REQ;
            default:  state_nxt = IFU_IDLE;
        endcase
        // Address only changes when a new request starts; held through REQ-wait and DROP.
        if (state_nxt == IFU_REQ) addr_nxt = fetch_pc_nxt;
    end

    // FSM, fetch PC and request address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IFU_IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            addr_q   <= addr_nxt;
        end
    end

    // Remember the last presented entry so ir/ir_pc hold while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      hold_q <= {NOP, 32'h0000_0000};
        else if (!empty) hold_q <= head;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic.
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_valid, ir_ready = 1'b0;
    logic [31:0] ir, ir_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_rdata = '0, fetch_pc_out;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
        .ir_pc(ir_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fetch_pc_out(fetch_pc_out)
    );

    int total = 0, bad = 0;

    // Reference model: prefetched entries as a queue, plus the in-flight request.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        q[$];
    ent_t        last;
    bit          m_busy, m_stale;
    logic [31:0] m_addr, m_pc;
    int          wcnt;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        last    = '{instr: 32'h0, pc: 32'h0};
        m_busy  = 0;
        m_stale = 0;
        m_addr  = RESET_PC;
        m_pc    = RESET_PC;
    endfunction

    // Advance the model by one clock edge given the inputs that were present before it.
    function automatic void model_step(input bit ack, input logic [31:0] rd, input bit ready,
                                       input bit rv, input logic [31:0] rpc);
        bit acked = m_busy && ack;
        if (q.size() > 0) last = q[0];
        if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_busy && !acked) m_stale = 1;
            else begin m_busy = 1; m_stale = 0; m_addr = m_pc; end
        end else begin
            if (q.size() > 0 && ready) void'(q.pop_front());
            if (acked) begin
                if (!m_stale) begin
                    q.push_back('{instr: rd, pc: m_addr});
                    m_pc = m_pc + 32'd4;
                end
                m_busy  = 0;
                m_stale = 0;
            end
            if (!m_busy && q.size() < DEPTH) begin m_busy = 1; m_addr = m_pc; end
        end
    endfunction

    task automatic compare_model();
        ent_t h;
        h = (q.size() > 0) ? q[0] : last;
        chk("ir_valid", 32'(ir_valid), 32'(q.size() > 0));
        chk("ir", ir, h.instr);
        chk("ir_pc", ir_pc, h.pc);
        chk("mem_req", 32'(mem_req), 32'(m_busy));
        chk("mem_addr", mem_addr, m_addr);
        chk("fetch_pc_out", fetch_pc_out, m_pc);
    endtask

    // Drive one cycle of inputs, take the edge, then check DUT against the model.
    task automatic cyc(input bit ack, input bit ready, input bit rv, input logic [31:0] rpc);
        logic [31:0] rd;
        rd = ack ? data_of(mem_addr) : 32'hDEAD_BEEF;
        mem_ack = ack; mem_rdata = rd; ir_ready = ready;
        redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk); #1;
        model_step(ack, rd, ready, rv, rpc);
        compare_model();
    endtask

    // Memory that acks on the fourth cycle of each request.
    task automatic dcyc(input bit ready, input bit rv, input logic [31:0] rpc);
        bit a;
        a = mem_req && (wcnt == 3);
        if (a) wcnt = 0; else if (mem_req) wcnt++;
        cyc(a, ready, rv, rpc);
    endtask

    task automatic do_reset();
        mem_ack = 0; ir_ready = 0; redirect_valid = 0; redirect_pc = '0; mem_rdata = '0;
        rst_n = 0;
        model_reset();
        wcnt = 0;
        @(posedge clk); #1;
        compare_model();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        int n, ack_pct, rdy_pct;
        bit saw8, a, r, rv;
        logic [31:0] rpc;

        // 1: streaming with ack and ready held high.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            cyc(1, 1, 0, '0);
            chk("t1_addr", mem_addr, 32'(4 * (k - 1)));
            if (k >= 2) begin
                chk("t1_vld", 32'(ir_valid), 32'd1);
                chk("t1_pc", ir_pc, 32'(4 * (k - 2)));
                chk("t1_ir", ir, data_of(32'(4 * (k - 2))));
            end
        end

        // 2: core stalled; fill to DEPTH then one pop frees one slot.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 0, 0, '0);
            if (k <= 4) begin
                chk("t2_req", 32'(mem_req), 32'd1);
                chk("t2_addr", mem_addr, 32'(4 * (k - 1)));
            end
        end
        chk("t2_full_noreq", 32'(mem_req), 32'd0);
        cyc(1, 0, 0, '0);
        chk("t2_still_noreq", 32'(mem_req), 32'd0);
        chk("t2_head", ir_pc, 32'h0);
        cyc(1, 1, 0, '0);
        chk("t2_req_after_pop", 32'(mem_req), 32'd1);
        chk("t2_addr10", mem_addr, 32'h10);
        chk("t2_head4", ir_pc, 32'h4);

        // 3: slow memory; redirect while the request to 0x8 is pending.
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 32'h8) && n < 60) begin dcyc(1, 0, '0); n++; end
        chk("t3_reach8", mem_addr, 32'h8);
        dcyc(1, 0, '0);
        dcyc(1, 1, 32'h40);
        chk("t3_hold8", mem_addr, 32'h8);
        chk("t3_req", 32'(mem_req), 32'd1);
        chk("t3_flushed", 32'(ir_valid), 32'd0);
        n = 0; saw8 = 0;
        while (mem_addr == 32'h8 && n < 20) begin
            dcyc(1, 0, '0);
            if (ir_valid && ir_pc == 32'h8) saw8 = 1;
            n++;
        end
        chk("t3_next_addr", mem_addr, 32'h40);
        n = 0;
        while (!ir_valid && n < 20) begin
            dcyc(1, 0, '0);
            if (ir_valid && ir_pc == 32'h8) saw8 = 1;
            n++;
        end
        chk("t3_first_pc", ir_pc, 32'h40);
        chk("t3_no8", 32'(saw8), 32'd0);

        // 4: redirect coincides with ack for 0xC.
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 32'hC) && n < 20) begin cyc(1, 1, 0, '0); n++; end
        chk("t4_reachC", mem_addr, 32'hC);
        chk("t4_vld_pre", 32'(ir_valid), 32'd1);
        cyc(1, 1, 1, 32'h80);
        chk("t4_vld", 32'(ir_valid), 32'd0);
        chk("t4_addr80", mem_addr, 32'h80);
        chk("t4_pc_hold", ir_pc, 32'h8);

        // 5: address wrap at the top of memory.
        cyc(1, 1, 1, 32'hFFFF_FFFF);
        chk("t5_addr_top", mem_addr, 32'hFFFF_FFFC);
        cyc(1, 1, 0, '0);
        chk("t5_addr_wrap", mem_addr, 32'h0);
        chk("t5_pc_top", ir_pc, 32'hFFFF_FFFC);
        cyc(1, 1, 0, '0);
        chk("t5_pc_wrap", ir_pc, 32'h0);
        chk("t5_addr4", mem_addr, 32'h4);

        // 6: reset mid-request, then a stale ack after release.
        cyc(0, 0, 0, '0);
        chk("t6_pre_req", 32'(mem_req), 32'd1);
        rst_n = 0;
        #1;
        chk("t6_req", 32'(mem_req), 32'd0);
        chk("t6_vld", 32'(ir_valid), 32'd0);
        chk("t6_addr", mem_addr, RESET_PC);
        chk("t6_fpc", fetch_pc_out, RESET_PC);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        cyc(1, 1, 0, '0);
        chk("t6_restart", mem_addr, RESET_PC);
        chk("t6_restart_req", 32'(mem_req), 32'd1);
        cyc(1, 1, 0, '0);
        chk("t6_first_pc", ir_pc, RESET_PC);

        // Randomized traffic against the model.
        do_reset();
        ack_pct = 100; rdy_pct = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                ack_pct = $urandom_range(0, 2) == 0 ? 100 : int'($urandom_range(10, 90));
                rdy_pct = $urandom_range(0, 2) == 0 ? 100 : int'($urandom_range(0, 90));
            end
            a  = mem_req ? (int'($urandom_range(0, 99)) < ack_pct) : ($urandom_range(0, 19) == 0);
            r  = int'($urandom_range(0, 99)) < rdy_pct;
            rv = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc(a, r, rv, rpc);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
